// File: rtl/addr_pkg.sv
// Shared types and mod-3 residue helpers for the digit-serial adder.
// Residue helpers are used only when ADDR_RESIDUE_CHECK_EN is defined.
package addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x must already be a residue (0..2); y may be any 2-bit chunk (0..3).
  function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= 3'd3) begin
      t = t - 3'd3;
    end else begin
      t = t;
    end
    return t[1:0];
  endfunction

  // 4^k == 1 (mod 3), so the residue is the folded sum of the 2-bit chunks.
  function automatic logic [1:0] mod3(input logic [63:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 32; i++) begin
      r = mod3_add(r, v[2*i +: 2]);
    end
    return r;
  endfunction

endpackage

// File: rtl/addr_digit.sv
// One DIGIT-bit ripple-carry adder slice with carry-in and carry-out.
module addr_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic c_s;

  // Bitwise ripple through the slice.
  always_comb begin
    s   = {DIGIT{1'b0}};
    c_s = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c_s;
      c_s  = (a[i] & b[i]) | (c_s & (a[i] ^ b[i]));
    end
    co = c_s;
  end

endmodule

// File: rtl/addr_serial_chk.sv
// Digit-serial adder: sum = a + b + cin computed DIGIT bits per cycle.
// Define ADDR_RESIDUE_CHECK_EN to add a mod-3 residue check driving err.
module addr_serial_chk
  import addr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N - 1);
  localparam logic [WIDTH:0]   SLICE_MASK = {{(WIDTH + 1 - DIGIT){1'b0}}, {DIGIT{1'b1}}};

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH:0]   sum_r;
  logic [WIDTH:0]   sum_nx_s;
  logic [31:0]      shamt_s;
  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT-1:0] s_dig_s;
  logic             co_s;
  logic             accept_s;
  logic             release_s;
  logic             last_s;

  // Handshake qualifiers and current slice selection.
  always_comb begin
    accept_s  = in_valid && (state_r == IDLE);
    release_s = out_ready && (state_r == DONE);
    last_s    = (cnt_r == CNT_LAST);
    shamt_s   = 32'(cnt_r) * 32'(DIGIT);
    a_dig_s   = DIGIT'(a_r >> shamt_s);
    b_dig_s   = DIGIT'(b_r >> shamt_s);
  end

  addr_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a  (a_dig_s),
    .b  (b_dig_s),
    .ci (carry_r),
    .s  (s_dig_s),
    .co (co_s)
  );

  // Merge the new slice into the partial sum; the MSB tracks the running carry-out.
  always_comb begin
    sum_nx_s        = (sum_r & ~(SLICE_MASK << shamt_s)) | ((WIDTH + 1)'(s_dig_s) << shamt_s);
    sum_nx_s[WIDTH] = co_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; no bypass from DONE straight into a new accept.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
  end

  // Operand capture and per-slice accumulation; sum only moves in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {(WIDTH + 1){1'b0}};
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (state_r == RUN) begin
      sum_r   <= sum_nx_s;
      carry_r <= co_s;
      cnt_r   <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    end
  end

  assign sum = sum_r;

`ifdef ADDR_RESIDUE_CHECK_EN
  logic [1:0] r_in_r;
  logic       err_r;

  // Residue predicted at accept, compared against the finished sum on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_r <= 2'd0;
      err_r  <= 1'b0;
    end else if (accept_s) begin
      r_in_r <= mod3_add(mod3_add(mod3(64'(a)), mod3(64'(b))), {1'b0, cin});
    end else if ((state_r == RUN) && last_s) begin
      err_r  <= (mod3(64'(sum_nx_s)) != r_in_r);
    end else if (release_s) begin
      err_r  <= 1'b0;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_addr_serial_chk.sv
// Scoreboard bench for addr_serial_chk: an 8-bit/2-bit and a 16-bit/4-bit instance.
module tb_addr_serial_chk;

  typedef struct {
    logic [16:0] sum;
    logic        err;
  } exp_t;

`ifdef ADDR_RESIDUE_CHECK_EN
  localparam logic FORCED_ERR = 1'b1;
`else
  localparam logic FORCED_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, err8;
  logic [7:0]  a8, b8;
  logic [8:0]  sum8;
  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, err16;
  logic [15:0] a16, b16;
  logic [16:0] sum16;

  exp_t q8[$];
  exp_t q16[$];
  int   n_vec = 0, n_mis = 0;
  int   n_push8 = 0, n_pop8 = 0, n_push16 = 0, n_pop16 = 0;
  bit   rand_rdy = 1'b0;

  addr_serial_chk #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .err(err8)
  );

  addr_serial_chk #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .err(err16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [8:0] es, input logic ee);
    int   t;
    exp_t x;
    t = 0;
    while (!in_ready8 && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_mis++;
      $display("FAIL in_ready8_timeout: waited %0d cycles, want in_ready=1", t);
    end
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    x.sum = 17'(es); x.err = ee;
    q8.push_back(x);
    n_push8++;
    step();
    in_valid8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [16:0] es);
    int   t;
    exp_t x;
    t = 0;
    while (!in_ready16 && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_mis++;
      $display("FAIL in_ready16_timeout: waited %0d cycles, want in_ready=1", t);
    end
    a16 = a; b16 = b; cin16 = c; in_valid16 = 1'b1;
    x.sum = es; x.err = 1'b0;
    q16.push_back(x);
    n_push16++;
    step();
    in_valid16 = 1'b0;
  endtask

  // Returns the cycle index (accept edge = 0) at which out_valid is first seen.
  task automatic wait_valid8(output int cyc);
    cyc = 1;
    while (!out_valid8 && cyc < 100) begin
      step();
      cyc++;
    end
    if (!out_valid8) begin
      n_vec++;
      n_mis++;
      $display("FAIL out_valid8_timeout: got 0 after %0d cycles, want 1", cyc);
    end
  endtask

  task automatic wait_valid16(output int cyc);
    cyc = 1;
    while (!out_valid16 && cyc < 100) begin
      step();
      cyc++;
    end
    if (!out_valid16) begin
      n_vec++;
      n_mis++;
      $display("FAIL out_valid16_timeout: got 0 after %0d cycles, want 1", cyc);
    end
  endtask

  // Monitor for the 8-bit instance: compare while valid, pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid8) begin
        n_vec++;
        if (q8.size() == 0) begin
          n_mis++;
          $display("FAIL out8_unexpected: got sum=%0h with nothing outstanding", sum8);
        end else begin
          if (sum8 !== q8[0].sum[8:0] || err8 !== q8[0].err) begin
            n_mis++;
            $display("FAIL out8: got sum=%0h err=%b, want sum=%0h err=%b",
                     sum8, err8, q8[0].sum[8:0], q8[0].err);
          end
          if (out_ready8) begin
            void'(q8.pop_front());
            n_pop8++;
          end
        end
      end
    end
  end

  // Monitor for the 16-bit instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid16) begin
        n_vec++;
        if (q16.size() == 0) begin
          n_mis++;
          $display("FAIL out16_unexpected: got sum=%0h with nothing outstanding", sum16);
        end else begin
          if (sum16 !== q16[0].sum || err16 !== q16[0].err) begin
            n_mis++;
            $display("FAIL out16: got sum=%0h err=%b, want sum=%0h err=%b",
                     sum16, err16, q16[0].sum, q16[0].err);
          end
          if (out_ready16) begin
            void'(q16.pop_front());
            n_pop16++;
          end
        end
      end
    end
  end

  // Random downstream back-pressure during the soak phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) out_ready8 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int cyc;
    int ra, rb, rc;
    rst = 1'b1;
    in_valid8 = 1'b0;  a8 = 8'd0;   b8 = 8'd0;   cin8 = 1'b0;  out_ready8 = 1'b1;
    in_valid16 = 1'b0; a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0; out_ready16 = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_err", 32'(err8), 32'd0);
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready8), 32'd1);

    // 0xFF + 0x01: carry ripples through every slice; valid on cycle N+1.
    send8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    check("busy_in_ready", 32'(in_ready8), 32'd0);
    wait_valid8(cyc);
    check("latency8", 32'(cyc), 32'd5);
    check("sum_ff_01", 32'(sum8), 32'h100);
    check("err_ff_01", 32'(err8), 32'd0);
    step();
    check("idle_after_hs", 32'(in_ready8), 32'd1);
    check("valid_after_hs", 32'(out_valid8), 32'd0);

    // Back-pressure: result must hold while out_ready is low.
    out_ready8 = 1'b0;
    send8(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0);
    wait_valid8(cyc);
    for (int i = 0; i < 3; i++) begin
      check("hold_sum", 32'(sum8), 32'h100);
      check("hold_in_ready", 32'(in_ready8), 32'd0);
      check("hold_valid", 32'(out_valid8), 32'd1);
      step();
    end
    out_ready8 = 1'b1;
    step();
    check("idle_after_ready", 32'(in_ready8), 32'd1);

    // Reset on the second RUN cycle discards the operation.
    send8(8'h11, 8'h22, 1'b0, 9'h033, 1'b0);
    step();
    rst = 1'b1;
    q8.delete();
    n_push8--;
    step();
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready8), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("rst_mid_no_valid", 32'(out_valid8), 32'd0);
      step();
    end
    send8(8'd3, 8'd4, 1'b0, 9'd7, 1'b0);
    wait_valid8(cyc);
    check("sum_3_4", 32'(sum8), 32'd7);
    step();

    // Corrupt the slice-0 carry: sum becomes 1 while the residue predicts 0.
    send8(8'h00, 8'h00, 1'b0, 9'h001, FORCED_ERR);
    force u8.carry_r = 1'b1;
    step();
    force u8.carry_r = 1'b0;
    #1;
    release u8.carry_r;
    wait_valid8(cyc);
    check("forced_sum", 32'(sum8), 32'h001);
    check("forced_err", 32'(err8), 32'(FORCED_ERR));
    step();

    send8(8'h80, 8'h80, 1'b1, 9'h101, 1'b0);
    send8(8'h0F, 8'h01, 1'b0, 9'h010, 1'b0);

    // Wider instance: four 4-bit slices.
    send16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    wait_valid16(cyc);
    check("latency16", 32'(cyc), 32'd5);
    check("sum16_max", 32'(sum16), 32'h1FFFF);
    step();
    send16(16'h1234, 16'h4321, 1'b0, 17'h05555);

    // Soak: back-to-back random operands against a + b + cin.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rc = int'($urandom_range(0, 1));
      send8(8'(ra), 8'(rb), 1'(rc), 9'(ra + rb + rc), 1'b0);
    end
    rand_rdy = 1'b0;
    out_ready8 = 1'b1;
    for (int i = 0; i < 200 && (q8.size() != 0 || q16.size() != 0); i++) step();
    step();
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);
    check("count8", 32'(n_pop8), 32'(n_push8));
    check("count16", 32'(n_pop16), 32'(n_push16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/addr_serial_chk.md
ADDR_SERIAL_CHK -- requirements
Module: addr_serial_chk

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (>= 2).
REQ-002 SHALL have parameter DIGIT, default 2, meaning bits added per cycle; WIDTH % DIGIT == 0 is required.
REQ-003 SHALL have port clk  input  1  the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, which is synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b and cin are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have ports a, b  input  WIDTH  unsigned operands.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  sum and err are valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port sum  output  WIDTH+1  unsigned result, with MSB = carry-out.
REQ-012 SHALL have port err  output  1  residue-check mismatch flag.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept operands on in_valid && in_ready, latching a, b and cin and clearing the digit counter; IDLE->RUN.
REQ-015 In RUN, SHALL add one DIGIT-bit slice per cycle, LSB slice first, with carry held in a register between slices.
REQ-016 SHALL spend exactly N=WIDTH/DIGIT cycles in RUN; after the Nth slice, RUN->DONE.
REQ-017 SHALL assert out_valid=1 in DONE only; the first out_valid cycle is N+1 cycles after the accept edge.
REQ-018 SHALL hold sum and err stable while out_valid && !out_ready.
REQ-019 On out_valid && out_ready, SHALL transition DONE->IDLE; a new operand is never accepted in the same cycle (no bypass), so throughput is one result per N+2 cycles minimum.
REQ-020 SHALL give sum the exact value a + b + cin; there is no overflow, because the width is WIDTH+1.
REQ-021 SHALL keep the sum register unchanged outside RUN, except at reset.
REQ-022 SHALL ignore in_valid while in RUN or DONE, and ignore out_ready while in IDLE or RUN.

Reset
REQ-023 While rst=1 at a clock edge, SHALL set the FSM to IDLE, sum=0, err=0, out_valid=0, the carry register to 0 and the counter to 0; in_ready SHALL be 1 in the cycle after reset releases.
REQ-024 SHALL have rst take priority over every handshake; an operation in RUN or DONE at the time of reset is discarded with no result emitted.

Configuration
REQ-025 With macro ADDR_RESIDUE_CHECK_EN defined, on accept SHALL capture r_in = (a mod 3 + b mod 3 + cin) mod 3.
REQ-026 With ADDR_RESIDUE_CHECK_EN defined, on entry to DONE SHALL set err = (sum mod 3 != r_in), held until the handshake.
REQ-027 With ADDR_RESIDUE_CHECK_EN undefined, SHALL tie err to 0 and include no residue logic; all other timing is identical.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, RUN, DONE) and a mod-3 residue function in shared package addr_pkg.
REQ-029 SHALL implement the per-cycle DIGIT-bit ripple adder with carry-in and carry-out as sub-module addr_digit, instantiated once.

Verification
REQ-030 SHALL verify: WIDTH=8, DIGIT=2, a=0xFF, b=0x01, cin=0 -> out_valid on cycle 5 after accept, sum=0x100, err=0.
REQ-031 SHALL verify: a=0xA5, b=0x5A, cin=1, out_ready held 0 for 3 cycles -> sum=0x100 held stable, in_ready=0 throughout, IDLE reached the cycle after out_ready=1.
REQ-032 SHALL verify: rst pulsed on the 2nd RUN cycle -> no out_valid, in_ready=1 the next cycle, next operation a=3, b=4 gives sum=7.
REQ-033 SHALL verify: with ADDR_RESIDUE_CHECK_EN, carry register forced to 1 during slice 0 of a=0, b=0 -> sum=0x001, err=1; with the macro undefined, err=0.
REQ-034 SHALL verify: WIDTH=16, DIGIT=4, a=0xFFFF, b=0xFFFF, cin=1 -> sum=0x1FFFF after 4 RUN cycles.
REQ-035 SHALL verify: 1000 random back-to-back transactions with random out_ready -> every sum matches the reference model, err=0, and no transaction is lost or duplicated.
